// File: rtl/sync_fifo_param_if.sv
// Request/response bundle for sync_fifo_param: write/read handshakes, flush and status.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              clr;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output clr, wr_en, wr_data, rd_en,
    input  rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, wr_data, rd_en,
    output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock first-word-fall-through FIFO with registered status flags,
// sticky overflow/underflow and a synchronous flush.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = (2**ADDR_W) - 2,
  parameter int AE_THRESH = 2
) (
  input  logic               clk,
  input  logic               rst,
  sync_fifo_param_if.slave   bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_T = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_T = (ADDR_W+1)'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr, rd_ptr, count, count_nxt;
  logic              full, empty, afull, aempty, ovf, udf;
  logic              wr_acc, rd_acc;

  assign wr_acc = bus.wr_en & ~full  & ~bus.clr;
  assign rd_acc = bus.rd_en & ~empty & ~bus.clr;

  always_comb begin
    count_nxt = count;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + ONE;
      2'b01:   count_nxt = count - ONE;
      default: count_nxt = count;
    endcase
  end

  // Flags are derived from the next count so they settle on the same edge as count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      afull  <= 1'b0;
      aempty <= 1'b1;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (bus.clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      afull  <= 1'b0;
      aempty <= 1'b1;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      count  <= count_nxt;
      full   <= (count_nxt == FULL_CNT);
      empty  <= (count_nxt == '0);
      afull  <= (count_nxt >= AF_T);
      aempty <= (count_nxt <= AE_T);
      if (bus.wr_en && full)  ovf <= 1'b1;
      if (bus.rd_en && empty) udf <= 1'b1;
    end
  end

  // Storage is left unreset; only the low pointer bits address it.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[ADDR_W-1:0]] <= bus.wr_data;
  end

  assign bus.rd_data      = mem[rd_ptr[ADDR_W-1:0]];
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = afull;
  assign bus.almost_empty = aempty;
  assign bus.count        = count;
  assign bus.overflow     = ovf;
  assign bus.underflow    = udf;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed and randomized checks of sync_fifo_param against a queue-based model.
module tb_sync_fifo_param;
  localparam int DW = 8, AW = 4, DEPTH = 16, AFT = 14, AET = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
  sync_fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AF_THRESH(AFT), .AE_THRESH(AET))
    dut (.clk(clk), .rst(rst), .bus(bus));

  logic [DW-1:0] q[$];
  bit m_ovf, m_udf;
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n = q.size();
    chk("count",        64'(bus.count),        64'(n));
    chk("full",         64'(bus.full),         64'(n == DEPTH));
    chk("empty",        64'(bus.empty),        64'(n == 0));
    chk("almost_full",  64'(bus.almost_full),  64'(n >= AFT));
    chk("almost_empty", 64'(bus.almost_empty), 64'(n <= AET));
    chk("overflow",     64'(bus.overflow),     64'(m_ovf));
    chk("underflow",    64'(bus.underflow),    64'(m_udf));
    if (n != 0) chk("rd_data", 64'(bus.rd_data), 64'(q[0]));
  endtask

  // One clock with the given requests; the model applies the FIFO rules to its pre-edge state.
  task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd, input bit cl);
    bit was_full, was_empty;
    bus.wr_en = wr; bus.wr_data = d; bus.rd_en = rd; bus.clr = cl;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    @(posedge clk); #1;
    if (cl) begin
      q.delete(); m_ovf = 0; m_udf = 0;
    end else begin
      if (wr && was_full)  m_ovf = 1;
      if (rd && was_empty) m_udf = 1;
      if (rd && !was_empty) void'(q.pop_front());
      if (wr && !was_full)  q.push_back(d);
    end
    bus.wr_en = 0; bus.rd_en = 0; bus.clr = 0;
    check_all();
  endtask

  task automatic do_reset_async();
    #2 rst = 0; #1;
    q.delete(); m_ovf = 0; m_udf = 0;
    check_all();
    @(negedge clk); rst = 1;
  endtask

  initial begin
    bus.wr_en = 0; bus.rd_en = 0; bus.clr = 0; bus.wr_data = '0;
    // Requests while in reset must be ignored.
    bus.wr_en = 1; bus.rd_en = 1;
    repeat (2) @(posedge clk);
    #1 check_all();
    bus.wr_en = 0; bus.rd_en = 0;
    @(negedge clk); rst = 1;
    @(posedge clk); #1 check_all();

    // Fill with 0x01..0x10, then drain in order.
    for (int i = 1; i <= 16; i++) step(1, 8'(i), 0, 0);
    for (int i = 1; i <= 16; i++) begin
      chk("drain_order", 64'(bus.rd_data), 64'(i));
      step(0, 8'h00, 1, 0);
    end

    // Write while full is rejected and sets overflow.
    for (int i = 0; i < 16; i++) step(1, 8'($urandom_range(0, 8'hA9)), 0, 0);
    step(1, 8'hAA, 0, 0);
    for (int i = 0; i < 16; i++) begin
      chk("no_aa", 64'(bus.rd_data == 8'hAA), 64'(0));
      step(0, 8'h00, 1, 0);
    end

    // Empty with both requests: write wins, underflow set.
    step(1, 8'h55, 1, 0);
    chk("fwft_55", 64'(bus.rd_data), 64'h55);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 1);

    // Sustained simultaneous traffic at count 8 across pointer wrap.
    for (int i = 0; i < 8; i++) step(1, 8'($urandom), 0, 0);
    for (int i = 0; i < 40; i++) step(1, 8'($urandom), 1, 0);

    // Count 5 with overflow set, then flush with a write pending.
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 17; i++) step(1, 8'($urandom), 0, 0);
    for (int i = 0; i < 11; i++) step(0, 8'h00, 1, 0);
    step(1, 8'hEE, 0, 1);

    // Asynchronous reset mid-operation at count 10.
    for (int i = 0; i < 10; i++) step(1, 8'($urandom), 0, 0);
    do_reset_async();
    step(1, 8'h77, 0, 0);
    chk("post_rst_77", 64'(bus.rd_data), 64'h77);
    step(0, 8'h00, 1, 0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0),
           ($urandom_range(0, 63) == 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
